// File: rtl/norm_shift_ctrl_pkg.sv
// Shared types and constants for the normalization shift controller.
package norm_shift_ctrl_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    GROUP,
    COMBINE,
    DONE
  } state_t;

  // Nibble groups needed to cover the significand below the carry bit.
  function automatic int unsigned num_groups(input int unsigned swr);
    return (swr - 1 + NIBBLE - 1) / NIBBLE;
  endfunction

endpackage

// File: rtl/norm_shift_ctrl_lzc_nibble.sv
// 4-bit leading-zero counter: all-zero flag plus 2-bit count (count is 3 when all zero).
module lzc_nibble
  import norm_shift_ctrl_pkg::*;
(
  input  logic [NIBBLE-1:0] nib,
  output logic              zero,
  output logic [1:0]        cnt
);

  always_comb begin
    zero = (nib == '0);
    if (nib[3])      cnt = 2'd0;
    else if (nib[2]) cnt = 2'd1;
    else if (nib[1]) cnt = 2'd2;
    else             cnt = 2'd3;
  end

endmodule

// File: rtl/norm_shift_ctrl.sv
// Control side of the normalization barrel shifter: pipelined leading-zero count,
// shift direction/amount, adjusted exponent and range flags, with start/valid/ack handshake.
module norm_shift_ctrl
  import norm_shift_ctrl_pkg::*;
#(
  parameter int unsigned SWR = 26,
  parameter int unsigned EWR = 5,
  parameter int unsigned EW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [SWR-1:0] data_i,
  input  logic [EW-1:0]  exp_i,
  input  logic           ack_i,
  output logic           busy_o,
  output logic           load_o,
  output logic           valid_o,
  output logic [EWR-1:0] shift_value_o,
  output logic           left_right_o,
  output logic           bit_shift_o,
  output logic [EW-1:0]  exp_o,
  output logic           zero_o,
  output logic           underflow_o,
  output logic           overflow_o
);

  localparam int unsigned NG   = num_groups(SWR);
  localparam int unsigned MW   = SWR - 1;
  localparam int unsigned PADW = NG * NIBBLE;

  state_t state_q, state_d;

  logic [SWR-1:0]     data_q;
  logic [EW-1:0]      exp_q;
  logic [PADW-1:0]    padded;
  logic [NG-1:0]      gz, gz_q;
  logic [NG-1:0][1:0] gc, gc_q;
  logic               carry_q;
  logic               all_zero_q;
  logic [EWR-1:0]     lzc_d, lzc_q;
  logic               found;

  logic               res_lr, res_z, res_u, res_o;
  logic [EWR-1:0]     res_sv;
  logic [EW-1:0]      res_exp;

  // MSB-align the fraction field so the final group is padded with zeros at its LSBs.
  assign padded = PADW'(data_q[MW-1:0]) << (PADW - MW);

  genvar g;
  generate
    for (g = 0; g < NG; g++) begin : g_grp
      lzc_nibble u_lzc (
        .nib  (padded[PADW-1-g*NIBBLE -: NIBBLE]),
        .zero (gz[g]),
        .cnt  (gc[g])
      );
    end
  endgenerate

  always_comb begin
    lzc_d = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NG; i++) begin
      if (!found && !gz_q[i]) begin
        found = 1'b1;
        lzc_d = EWR'(i * NIBBLE + gc_q[i]);
      end
    end
  end

  // Priority: carry (right by one) > all-zero > left normalize.
  always_comb begin
    res_lr  = 1'b1;
    res_sv  = '0;
    res_exp = '0;
    res_z   = 1'b0;
    res_u   = 1'b0;
    res_o   = 1'b0;
    if (carry_q) begin
      res_lr = 1'b0;
      res_sv = EWR'(1);
      if (exp_q == '1) begin
        res_o   = 1'b1;
        res_exp = '1;
      end else begin
        res_exp = exp_q + 1'b1;
      end
    end else if (all_zero_q) begin
      res_z = 1'b1;
    end else begin
      res_sv = lzc_q;
      if (exp_q >= EW'(lzc_q)) res_exp = exp_q - EW'(lzc_q);
      else                     res_u   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = CAPTURE;
      CAPTURE: state_d = GROUP;
      GROUP:   state_d = COMBINE;
      COMBINE: state_d = DONE;
      DONE:    if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q        <= '0;
      exp_q         <= '0;
      gz_q          <= '0;
      gc_q          <= '0;
      carry_q       <= 1'b0;
      all_zero_q    <= 1'b0;
      lzc_q         <= '0;
      load_o        <= 1'b0;
      valid_o       <= 1'b0;
      shift_value_o <= '0;
      left_right_o  <= 1'b0;
      exp_o         <= '0;
      zero_o        <= 1'b0;
      underflow_o   <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      load_o <= (state_q == COMBINE);
      case (state_q)
        IDLE: if (start_i) begin
          data_q      <= data_i;
          exp_q       <= exp_i;
          zero_o      <= 1'b0;
          underflow_o <= 1'b0;
          overflow_o  <= 1'b0;
        end
        CAPTURE: begin
          gz_q    <= gz;
          gc_q    <= gc;
          carry_q <= data_q[SWR-1];
        end
        GROUP: begin
          lzc_q      <= lzc_d;
          all_zero_q <= &gz_q;
        end
        COMBINE: begin
          valid_o       <= 1'b1;
          shift_value_o <= res_sv;
          left_right_o  <= res_lr;
          exp_o         <= res_exp;
          zero_o        <= res_z;
          underflow_o   <= res_u;
          overflow_o    <= res_o;
        end
        DONE: if (ack_i) valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign bit_shift_o = 1'b0;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Directed self-checking bench for norm_shift_ctrl (SWR=26, EWR=5, EW=8).
module tb_norm_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic [25:0] data = '0;
  logic [7:0]  expi = '0;

  logic       busy_o, load_o, valid_o, left_right_o, bit_shift_o;
  logic [4:0] shift_value_o;
  logic [7:0] exp_o;
  logic       zero_o, underflow_o, overflow_o;

  int n_cmp = 0;
  int n_err = 0;
  int loads;
  int seen;

  norm_shift_ctrl #(.SWR(26), .EWR(5), .EW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .data_i        (data),
    .exp_i         (expi),
    .ack_i         (ack),
    .busy_o        (busy_o),
    .load_o        (load_o),
    .valid_o       (valid_o),
    .shift_value_o (shift_value_o),
    .left_right_o  (left_right_o),
    .bit_shift_o   (bit_shift_o),
    .exp_o         (exp_o),
    .zero_o        (zero_o),
    .underflow_o   (underflow_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_results(input string tag, input logic lr, input logic [4:0] sv,
                               input logic [7:0] e, input logic z, input logic u, input logic o);
    check({tag, ".lr"},   32'(left_right_o),  32'(lr));
    check({tag, ".sv"},   32'(shift_value_o), 32'(sv));
    check({tag, ".exp"},  32'(exp_o),         32'(e));
    check({tag, ".zero"}, 32'(zero_o),        32'(z));
    check({tag, ".uf"},   32'(underflow_o),   32'(u));
    check({tag, ".of"},   32'(overflow_o),    32'(o));
    check({tag, ".fill"}, 32'(bit_shift_o),   32'(0));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".busy"},  32'(busy_o),        32'(0));
    check({tag, ".valid"}, 32'(valid_o),       32'(0));
    check({tag, ".load"},  32'(load_o),        32'(0));
    check({tag, ".sv"},    32'(shift_value_o), 32'(0));
    check({tag, ".lr"},    32'(left_right_o),  32'(0));
    check({tag, ".exp"},   32'(exp_o),         32'(0));
    check({tag, ".flags"}, 32'({zero_o, underflow_o, overflow_o}), 32'(0));
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic launch(input string tag, input logic [25:0] d, input logic [7:0] e);
    @(negedge clk);
    data  = d;
    expi  = e;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = ~d;
    expi  = ~e;
    check({tag, ".busy"},  32'(busy_o), 32'(1));
    check({tag, ".flagsclr"}, 32'({zero_o, underflow_o, overflow_o}), 32'(0));
  endtask

  // Three more edges after acceptance reach DONE (cycle 4).
  task automatic await_done(input string tag);
    repeat (2) @(posedge clk);
    #1;
    check({tag, ".early"}, 32'(valid_o), 32'(0));
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(valid_o), 32'(1));
    check({tag, ".load"},  32'(load_o),  32'(1));
  endtask

  task automatic release_ack(input string tag);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    check({tag, ".ackvalid"}, 32'(valid_o), 32'(0));
    check({tag, ".ackbusy"},  32'(busy_o),  32'(0));
    check({tag, ".ackload"},  32'(load_o),  32'(0));
  endtask

  initial begin
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b1;

    launch("carry", 26'h2000000, 8'h80);
    await_done("carry");
    check_results("carry", 1'b0, 5'd1, 8'h81, 1'b0, 1'b0, 1'b0);
    release_ack("carry");

    launch("norm", 26'h1000000, 8'h80);
    await_done("norm");
    check_results("norm", 1'b1, 5'd0, 8'h80, 1'b0, 1'b0, 1'b0);
    release_ack("norm");

    launch("deep", 26'h0000001, 8'h80);
    await_done("deep");
    check_results("deep", 1'b1, 5'd24, 8'h68, 1'b0, 1'b0, 1'b0);
    release_ack("deep");

    launch("zero", 26'h0000000, 8'h55);
    await_done("zero");
    check_results("zero", 1'b1, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    release_ack("zero");

    launch("uflow", 26'h0000100, 8'h03);
    await_done("uflow");
    check_results("uflow", 1'b1, 5'd16, 8'h00, 1'b0, 1'b1, 1'b0);
    release_ack("uflow");

    launch("oflow", 26'h3000000, 8'hFF);
    await_done("oflow");
    check_results("oflow", 1'b0, 5'd1, 8'hFF, 1'b0, 1'b0, 1'b1);
    release_ack("oflow");

    // Bit 18 set: lzc 6, exponent 0x20 - 6 = 0x1A; a start during CAPTURE must be ignored.
    launch("hold", 26'h0040000, 8'h20);
    @(negedge clk);
    data  = 26'h0;
    expi  = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("hold.early", 32'(valid_o), 32'(0));
    @(posedge clk);
    #1;
    check("hold.valid", 32'(valid_o), 32'(1));
    check("hold.load",  32'(load_o),  32'(1));
    check_results("hold.entry", 1'b1, 5'd6, 8'h1A, 1'b0, 1'b0, 1'b0);
    loads = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 3);
      @(posedge clk);
      #1;
      start = 1'b0;
      loads += int'(load_o);
      check("hold.valid_held", 32'(valid_o), 32'(1));
      check("hold.exp_held",   32'(exp_o),   32'(8'h1A));
    end
    check("hold.extra_loads", 32'(loads), 32'(0));
    check_results("hold.end", 1'b1, 5'd6, 8'h1A, 1'b0, 1'b0, 1'b0);
    release_ack("hold");
    repeat (2) @(posedge clk);
    #1;
    check("hold.noqueue_busy",  32'(busy_o),  32'(0));
    check("hold.noqueue_valid", 32'(valid_o), 32'(0));

    // Bit 23: lzc 1, exponent 0x10 - 1 = 0x0F; ack raised on the DONE entry cycle.
    launch("entryack", 26'h0800000, 8'h10);
    await_done("entryack");
    check_results("entryack", 1'b1, 5'd1, 8'h0F, 1'b0, 1'b0, 1'b0);
    release_ack("entryack");

    // Reset asserted while in GROUP.
    launch("rstmid", 26'h0000010, 8'h40);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_cleared("rstmid");
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen += int'(valid_o) + int'(busy_o);
    end
    check("rstmid.no_valid", 32'(seen), 32'(0));

    // Bit 4: lzc 20, exponent 0x40 - 20 = 0x2C.
    launch("after", 26'h0000010, 8'h40);
    await_done("after");
    check_results("after", 1'b1, 5'd20, 8'h2C, 1'b0, 1'b0, 1'b0);
    release_ack("after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
